// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
//   i_inst_addr  : fetch address, driven by the fetch unit (master)
//   i_inst_rdata : instruction word, returned combinationally by the memory (slave)
interface pc_fetch_unit_if;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;

  modport master (
    output i_inst_addr,
    input  i_inst_rdata
  );

  modport slave (
    input  i_inst_addr,
    output i_inst_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, selects the next PC, and presents the fetched
// instruction with its address-error status to the IF/ID register.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   En_F                : stall enable (0 holds the stage)
//   Req                 : exception/interrupt request, redirects to HANDLER_PC
//   eret_D, EPC         : D-stage eret and its return address
//   Branch_D, Taken_D,
//   Target_D            : D-stage branch/jump, taken flag and target
//   imem                : instruction-memory bus (address out, read data in)
//   PC_F                : current fetch PC
//   Instruction_F       : instruction toward IF/ID (0 when squashed or faulting)
//   Error_F, ExcCode_F  : fetch address error and its code (AdEL = 4)
//   BDIn_F              : F instruction sits in a branch delay slot
//   fetch_cnt           : number of fetch cycles accepted into IF/ID
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En_F,
  input  logic              Req,
  input  logic              eret_D,
  input  logic [31:0]       EPC,
  input  logic              Branch_D,
  input  logic              Taken_D,
  input  logic [31:0]       Target_D,
  pc_fetch_unit_if.master   imem,
  output logic [31:0]       PC_F,
  output logic [31:0]       Instruction_F,
  output logic              Error_F,
  output logic [4:0]        ExcCode_F,
  output logic              BDIn_F,
  output logic [31:0]       fetch_cnt
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] cnt_reg;
  logic [31:0] cnt_next;
  logic        addr_fault;
  logic        eret_squash;

  // Next-PC selection. Req wins even over a stall so an exception is never
  // lost while the pipeline is frozen.
  always_comb begin
    pc_next = pc_reg;
    if (Req) begin
      pc_next = HANDLER_PC;
    end else if (En_F) begin
      if (eret_D) begin
        pc_next = EPC;
      end else if (Branch_D && Taken_D) begin
        pc_next = Target_D;
      end else begin
        pc_next = pc_reg + 32'd4;
      end
    end
  end

  // A fetch is accepted into IF/ID only when the stage advances normally;
  // an exception flush does not count.
  always_comb begin
    cnt_next = cnt_reg;
    if (En_F && !Req) begin
      cnt_next = cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg  <= RESET_PC;
      cnt_reg <= 32'd0;
    end else begin
      pc_reg  <= pc_next;
      cnt_reg <= cnt_next;
    end
  end

  // Misaligned or outside the instruction-memory window.
  assign addr_fault = (pc_reg[1:0] != 2'b00) || (pc_reg < IM_LO) || (pc_reg > IM_HI);

  // eret has no delay slot: whatever is in F behind it is discarded, including
  // any address error it would have raised.
  assign eret_squash = eret_D && En_F;

  assign imem.i_inst_addr = pc_reg;
  assign PC_F             = pc_reg;
  assign fetch_cnt        = cnt_reg;
  assign BDIn_F           = Branch_D;
  assign Error_F          = addr_fault && !eret_squash;
  assign ExcCode_F        = (addr_fault && !eret_squash) ? EXC_ADEL : 5'd0;
  assign Instruction_F    = (addr_fault || eret_squash) ? 32'd0 : imem.i_inst_rdata;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFF;

  logic        clk = 1'b0;
  logic        reset, En_F, Req, eret_D, Branch_D, Taken_D;
  logic [31:0] EPC, Target_D;
  logic [31:0] PC_F, Instruction_F, fetch_cnt;
  logic        Error_F, BDIn_F;
  logic [4:0]  ExcCode_F;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  pc_fetch_unit_if bus ();
  assign bus.i_inst_rdata = mem_word(bus.i_inst_addr);

  pc_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .HANDLER_PC(HANDLER_PC),
    .IM_LO     (IM_LO),
    .IM_HI     (IM_HI)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .En_F         (En_F),
    .Req          (Req),
    .eret_D       (eret_D),
    .EPC          (EPC),
    .Branch_D     (Branch_D),
    .Taken_D      (Taken_D),
    .Target_D     (Target_D),
    .imem         (bus),
    .PC_F         (PC_F),
    .Instruction_F(Instruction_F),
    .Error_F      (Error_F),
    .ExcCode_F    (ExcCode_F),
    .BDIn_F       (BDIn_F),
    .fetch_cnt    (fetch_cnt)
  );

  typedef struct {
    logic        rst, en, req, eret;
    logic [31:0] epc;
    logic        br, tk;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_err;
    logic        exp_zero;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: what the fetch stage should hold.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_valid = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit is_bad_addr(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

  // Compare every combinational output against the model for the current inputs.
  task automatic check_comb(input string tag);
    bit bad, squash, err;
    bad    = is_bad_addr(m_pc);
    squash = eret_D && En_F;
    err    = bad && !squash;
    check({tag, " pc"},    PC_F, m_pc);
    check({tag, " addr"},  bus.i_inst_addr, m_pc);
    check({tag, " cnt"},   fetch_cnt, m_cnt);
    check({tag, " err"},   {31'd0, Error_F}, {31'd0, err});
    check({tag, " code"},  {27'd0, ExcCode_F}, err ? 32'd4 : 32'd0);
    check({tag, " inst"},  Instruction_F, (bad || squash) ? 32'd0 : mem_word(m_pc));
    check({tag, " bd"},    {31'd0, BDIn_F}, {31'd0, Branch_D});
  endtask

  // Model state update, written straight from the priority rules.
  task automatic model_edge();
    if (reset) begin
      m_pc  = RESET_PC;
      m_cnt = 0;
      m_valid = 1;
    end else begin
      if (En_F && !Req) m_cnt = m_cnt + 1;
      if (Req)                       m_pc = HANDLER_PC;
      else if (!En_F)                m_pc = m_pc;
      else if (eret_D)               m_pc = EPC;
      else if (Branch_D && Taken_D)  m_pc = Target_D;
      else                           m_pc = m_pc + 4;
    end
  endtask

  // One cycle: drive on the falling edge, check combinational outputs midway,
  // then let the rising edge advance both DUT and model.
  task automatic cycle(input logic r, en, rq, er, input logic [31:0] epc,
                       input logic b, t, input logic [31:0] tg, input string tag);
    @(negedge clk);
    reset = r; En_F = en; Req = rq; eret_D = er; EPC = epc;
    Branch_D = b; Taken_D = t; Target_D = tg;
    #1;
    if (m_valid) check_comb(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic add(input logic r, en, rq, er, input logic [31:0] epc,
                     input logic b, t, input logic [31:0] tg,
                     input logic [31:0] pc, cnt, input logic err, zero);
    vec_t v;
    v = '{r, en, rq, er, epc, b, t, tg, pc, cnt, err, zero};
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1; En_F = 0; Req = 0; eret_D = 0; EPC = 0;
    Branch_D = 0; Taken_D = 0; Target_D = 0;

    //   rst en req eret epc           br tk tgt            pc             cnt err zero
    add(1, 0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3000, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3004, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3008, 2, 0, 0);
    add(0, 1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_300C, 3, 0, 0);
    add(1, 1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3000, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3004, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3008, 2, 0, 0);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0000_3100,  32'h0000_3100, 3, 0, 0);
    add(0, 1, 0, 0, 32'h0,          0, 1, 32'h0000_5000,  32'h0000_3104, 4, 0, 0);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0000_3010,  32'h0000_3010, 5, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3010, 5, 0, 0);
    add(0, 0, 0, 0, 32'h0,          1, 1, 32'h0000_5000,  32'h0000_3010, 5, 0, 0);
    add(0, 0, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0000_4180, 5, 0, 0);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0000_3102,  32'h0000_3102, 6, 1, 1);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0000_2FFC,  32'h0000_2FFC, 7, 1, 1);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0000_7000,  32'h0000_7000, 8, 1, 1);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h0000_5000,  32'h0000_4180, 8, 0, 0);
    add(0, 1, 0, 1, 32'h0000_3020,  0, 0, 32'h0,          32'h0000_3020, 9, 0, 1);
    add(0, 1, 1, 1, 32'h0000_3020,  1, 1, 32'h0000_5000,  32'h0000_4180, 9, 0, 1);
    add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_5000,  32'h0000_3000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          1, 1, 32'h0000_5000,  32'h0000_3000, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_3000, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 1, 1, 1);
    add(0, 1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_0000, 2, 1, 1);

    // Directed table: after each edge, with the row's inputs still applied,
    // compare against the hand-computed expectations.
    foreach (tbl[i]) begin
      vec_t v;
      string tag;
      v = tbl[i];
      tag = $sformatf("vec%0d", i);
      cycle(v.rst, v.en, v.req, v.eret, v.epc, v.br, v.tk, v.tgt, tag);
      check({tag, " pc_after"},  PC_F, v.exp_pc);
      check({tag, " cnt_after"}, fetch_cnt, v.exp_cnt);
      check({tag, " err_after"}, {31'd0, Error_F}, {31'd0, v.exp_err});
      check({tag, " code_after"}, {27'd0, ExcCode_F}, v.exp_err ? 32'd4 : 32'd0);
      check({tag, " inst_after"}, Instruction_F, v.exp_zero ? 32'd0 : mem_word(v.exp_pc));
      check({tag, " bd_after"},  {31'd0, BDIn_F}, {31'd0, v.br});
      $display("vec%0d: pc=%h cnt=%0d err=%b inst=%h", i, PC_F, fetch_cnt, Error_F, Instruction_F);
    end

    // Hand sequence: reset pulse in the middle of a stall with a pending
    // taken branch must discard it and restart cleanly.
    cycle(0, 1, 0, 0, 0, 0, 0, 0, "seq_a");
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h0000_6000, "seq_b");
    cycle(1, 0, 1, 1, 32'h0000_5000, 1, 1, 32'h0000_6000, "seq_c");
    cycle(0, 1, 0, 0, 0, 0, 0, 0, "seq_d");
    check("seq pc", PC_F, 32'h0000_3004);
    check("seq cnt", fetch_cnt, 32'd1);
    $display("seq: pc=%h cnt=%0d", PC_F, fetch_cnt);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic r, en, rq, er, b, t;
      logic [31:0] epc, tg;
      r  = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 75);
      rq = ($urandom_range(0, 99) < 5);
      er = ($urandom_range(0, 99) < 8);
      b  = ($urandom_range(0, 99) < 30);
      t  = $urandom_range(0, 1);
      tg = ($urandom_range(0, 9) == 0) ? $urandom()
                                       : ($urandom_range(IM_LO >> 2, IM_HI >> 2) << 2);
      epc = ($urandom_range(0, 9) == 0) ? $urandom()
                                        : ($urandom_range(IM_LO >> 2, IM_HI >> 2) << 2);
      cycle(r, en, rq, er, epc, b, t, tg, $sformatf("rnd%0d", n));
      $display("rnd%0d: rst=%b en=%b req=%b eret=%b br=%b tk=%b pc=%h cnt=%0d",
               n, r, en, rq, er, b, t, PC_F, fetch_cnt);
    end

    @(negedge clk);
    check_comb("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
